quad_velocity: RTL and testbench
================================

// Module: quad_velocity
// PURPOSE
//  Quadrature encoder front end for one motor channel. Synchronises and
//  deglitches raw encoder A/B lines, decodes x4 quadrature steps and counts
//  signed steps over a fixed sample window.
//  At each window end it publishes a saturated N-bit two's-complement
//  velocity on enc, which feeds the pid block's enc input directly.
// PARAMETERS
//  N       8      width of velocity output (two's complement)
//  WINDOW  55610  sample window in clk cycles (1.5 ms; matches pid update)
//  FILT    3      cycles a synchronised A/B pair must be stable to be accepted (>=1)
// PORTS
//  clk       in   1  system clock
//  rst_n     in   1  asynchronous active-low reset
//  enc_a     in   1  raw encoder channel A (asynchronous)
//  enc_b     in   1  raw encoder channel B (asynchronous)
//  err_clr   in   1  synchronous clear of err_flag
//  enc       out  N  signed steps counted in last window, saturated
//  vel_valid out  1  one-cycle pulse, coincident with each enc update
//  dir       out  1  1 = last accepted step was reverse, 0 = forward
//  err_flag  out  1  sticky: illegal (double-step) transition seen
// BEHAVIOUR
//  Reset:
//   - Asserting rst_n low asynchronously clears all state; effective in any cycle, mid-window included.
//   - Outputs: enc=0, vel_valid=0, dir=0, err_flag=0.
//   - Window counter and accumulator are cleared. Filtered AB state loads 00; sync flops clear.
//   - After release, the first window is a full WINDOW cycles.
//  Input path:
//   - 2-flop synchroniser per line, then stability filter.
//   - The filtered AB pair updates only after the synchronised pair has held one value for FILT consecutive cycles.
//   - Shorter pulses are discarded.
//   - Latency, pin edge to counted step: 2 + FILT cycles.
//  Decode:
//   - Operates on the previous and new filtered AB value.
//   - Forward Gray order is 00->01->11->10->00; each forward step adds +1.
//   - The reverse order adds -1.
//   - Unchanged AB adds 0.
//   - A two-bit change (00<->11, 01<->10) adds 0 and sets err_flag.
//   - dir updates only on legal steps.
//  Error flag:
//   - err_flag stays set until err_clr=1 is sampled.
//   - If err_clr and a new illegal transition occur in the same cycle, the flag stays set.
//  Window:
//   - Counter wcnt runs 0..WINDOW-1 and wraps to 0.
//   - Accumulator width is clog2(WINDOW)+2 bits (signed). It cannot overflow within one window.
//  Window end (cycle with wcnt==WINDOW-1):
//   - enc <= sat(acc + step), the registered value visible next cycle.
//   - Saturation limits are -2^(N-1) and 2^(N-1)-1. For N=8 this is -128..127.
//   - acc <= 0, so no step is lost or double-counted at the boundary. A step in the boundary cycle belongs to the closing window.
//   - vel_valid is asserted in the same cycle enc takes its new value.
//  Steady state: enc holds between updates. vel_valid is high exactly one cycle per WINDOW cycles.
// TESTING (bench uses WINDOW=100, FILT=3, N=8)
//  1. Forward count: 10 forward steps, 6 cycles apart, inside one window.
//     -> enc=10 and one vel_valid at the window end; dir=0.
//  2. Reverse count: 20 reverse steps in one window.
//     -> enc=8'hEC (-20); dir=1.
//  3. Saturation: WINDOW=1000, 150 forward steps in one window -> enc=127.
//     Then 150 reverse steps -> enc=-128 (8'h80).
//  4. Glitch and illegal transition:
//     - A pulses high for 2 cycles -> no count change.
//     - AB 00->11, held 5 cycles -> err_flag=1, enc unchanged by it.
//     - err_clr pulse -> err_flag=0.
//  5. Boundary: an accepted step lands on the wcnt==99 cycle.
//     -> counted in that window's enc; next window starts from 0.
//  6. Reset mid-window: rst_n low at wcnt=50, with acc=7.
//     -> enc=0 immediately (asynchronous).
//     -> after release, the next vel_valid comes exactly 100 cycles later, with only post-reset steps counted.

Source files
------------

// File: rtl/quad_velocity.sv
// Quadrature encoder front end: synchronise and deglitch A/B, decode x4 steps,
// and publish a saturated signed step count once per sample window.
module quad_velocity #(
    parameter int N      = 8,
    parameter int WINDOW = 55610,
    parameter int FILT   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enc_a,
    input  logic                enc_b,
    input  logic                err_clr,
    output logic signed [N-1:0] enc,
    output logic                vel_valid,
    output logic                dir,
    output logic                err_flag
);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int AW = $clog2(WINDOW) + 2;
    localparam int SW = ((AW > N) ? AW : N) + 1;
    localparam int RW = $clog2(FILT + 1) + 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (N - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

    logic [1:0]           s1_q, s1_d, s2_q, s2_d, last_q, last_d, filt_q, filt_d;
    logic [RW-1:0]        run_q, run_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [N-1:0]  enc_q, enc_d;
    logic                 vv_q, vv_d, dir_q, dir_d, err_q, err_d;

    logic                 accept, fwd, rev, bad, wend;
    logic [1:0]           pos_old, pos_new, delta;
    logic signed [1:0]    step;
    logic signed [AW-1:0] sum;
    logic signed [SW-1:0] sum_w;

    always_comb begin
        s1_d   = {enc_a, enc_b};
        s2_d   = s1_q;
        last_d = s2_q;

        // run_d counts consecutive cycles the synchronised pair has held, including this one
        if (s2_q != last_q)
            run_d = RW'(1);
        else if (run_q < RW'(FILT))
            run_d = run_q + RW'(1);
        else
            run_d = run_q;

        accept = (run_d >= RW'(FILT)) && (s2_q != filt_q);
        filt_d = accept ? s2_q : filt_q;

        // Gray code to position 0..3 so the step is just the modulo-4 difference
        pos_old = {filt_q[1], ^filt_q};
        pos_new = {s2_q[1], ^s2_q};
        delta   = pos_new - pos_old;
        fwd     = accept && (delta == 2'd1);
        rev     = accept && (delta == 2'd3);
        bad     = accept && (delta == 2'd2);
        step    = fwd ? 2'sb01 : (rev ? 2'sb11 : 2'sb00);

        dir_d = fwd ? 1'b0 : (rev ? 1'b1 : dir_q);
        err_d = bad | (err_q & ~err_clr);

        wend   = (wcnt_q == WW'(WINDOW - 1));
        wcnt_d = wend ? '0 : wcnt_q + WW'(1);
        sum    = acc_q + AW'(step);
        sum_w  = SW'(sum);
        acc_d  = wend ? '0 : sum;
        vv_d   = wend;

        enc_d = enc_q;
        if (wend) begin
            if (sum_w > SAT_HI)
                enc_d = SAT_HI[N-1:0];
            else if (sum_w < SAT_LO)
                enc_d = SAT_LO[N-1:0];
            else
                enc_d = sum_w[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            last_q <= '0;
            filt_q <= '0;
            run_q  <= '0;
            wcnt_q <= '0;
            acc_q  <= '0;
            enc_q  <= '0;
            vv_q   <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            last_q <= last_d;
            filt_q <= filt_d;
            run_q  <= run_d;
            wcnt_q <= wcnt_d;
            acc_q  <= acc_d;
            enc_q  <= enc_d;
            vv_q   <= vv_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    assign enc       = enc_q;
    assign vel_valid = vv_q;
    assign dir       = dir_q;
    assign err_flag  = err_q;
endmodule

// File: tb/tb_quad_velocity.sv
// Bench for quad_velocity: two instances (100- and 1000-cycle windows) share the
// encoder pins; a sample-history model checks every cycle, plus directed sequences.
module tb_quad_velocity;
    localparam int N = 8, FILT = 3, W0 = 100, W1 = 1000;

    logic clk = 1'b0;
    logic rst_n, enc_a, enc_b, err_clr;
    logic signed [N-1:0] enc0, enc1;
    logic vv0, vv1, dir0, dir1, err0, err1;

    always #5 clk = ~clk;

    quad_velocity #(.N(N), .WINDOW(W0), .FILT(FILT)) u_w100 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
        .enc(enc0), .vel_valid(vv0), .dir(dir0), .err_flag(err0));
    quad_velocity #(.N(N), .WINDOW(W1), .FILT(FILT)) u_w1000 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
        .enc(enc1), .vel_valid(vv1), .dir(dir1), .err_flag(err1));

    int tests = 0, fails = 0;
    int cyc;
    int pos_tb = 0;
    bit mon_en = 0;

    // ---------------- reference model ----------------
    // h[k] = pin pair sampled k+1 edges ago; a value is accepted once the
    // samples 2..FILT+1 edges old all agree and differ from the filtered value.
    logic [1:0] h [0:FILT];
    logic [1:0] m_filt;
    int m_n;
    int m_acc [2];
    int m_enc [2];
    bit m_vv [2];
    bit m_dir, m_err;

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // 0 none, +1 forward, -1 reverse, 2 illegal
    function automatic int cand_step();
        if (h[1] == m_filt) return 0;
        for (int i = 2; i <= FILT; i++)
            if (h[i] != h[1]) return 0;
        case ((gpos(h[1]) - gpos(m_filt) + 4) % 4)
            1: return 1;
            3: return -1;
            default: return 2;
        endcase
    endfunction

    function automatic int step_val();
        int c = cand_step();
        return (c == 2) ? 0 : c;
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= FILT; i++) h[i] <= 2'b00;
            m_filt <= 2'b00;
            m_n    <= 0;
            m_dir  <= 1'b0;
            m_err  <= 1'b0;
            for (int j = 0; j < 2; j++) begin
                m_acc[j] <= 0;
                m_enc[j] <= 0;
                m_vv[j]  <= 1'b0;
            end
        end else begin
            h[0] <= {enc_a, enc_b};
            for (int i = 1; i <= FILT; i++) h[i] <= h[i-1];
            if (cand_step() != 0) m_filt <= h[1];
            if (cand_step() == 1) m_dir <= 1'b0;
            if (cand_step() == -1) m_dir <= 1'b1;
            m_err <= (cand_step() == 2) || (m_err && !err_clr);
            m_n   <= m_n + 1;
            for (int j = 0; j < 2; j++) begin
                if ((m_n + 1) % (j == 0 ? W0 : W1) == 0) begin
                    m_enc[j] <= sat8(m_acc[j] + step_val());
                    m_acc[j] <= 0;
                    m_vv[j]  <= 1'b1;
                end else begin
                    m_acc[j] <= m_acc[j] + step_val();
                    m_vv[j]  <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic signed [7:0] e, input logic v,
                           input logic d, input logic r, input logic signed [7:0] xe,
                           input logic xv, input logic xd, input logic xr);
        tests++;
        if ({e, v, d, r} !== {xe, xv, xd, xr}) begin
            fails++;
            $display("FAIL %s t=%0t: got enc=%0d vv=%b dir=%b err=%b, required enc=%0d vv=%b dir=%b err=%b",
                     name, $time, e, v, d, r, xe, xv, xd, xr);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk_out("model_w100", enc0, vv0, dir0, err0, 8'(m_enc[0]), m_vv[0], m_dir, m_err);
            chk_out("model_w1000", enc1, vv1, dir1, err1, 8'(m_enc[1]), m_vv[1], m_dir, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mv(input int dirn, input int gap);
        pos_tb = (pos_tb + dirn + 4) % 4;
        {enc_a, enc_b} = ab_of(pos_tb);
        tick(gap);
    endtask

    task automatic wait_vv(input int idx, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((idx == 0 ? vv0 : vv1) === 1'b1) return;
        end
        tests++;
        fails++;
        $display("FAIL vel_valid_timeout dut=%0d: got no pulse in %0d cycles, required one", idx, limit);
    endtask

    typedef struct {
        int nsteps;
        int dirn;
        int gap;
        int exp_enc;
        int exp_dir;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [5];
        int e2;
        vt[0] = '{10,  1, 6,  10, 0};
        vt[1] = '{20, -1, 4, -20, 1};
        vt[2] = '{ 0,  1, 5,   0, 1};
        vt[3] = '{30,  1, 3,  30, 0};
        vt[4] = '{ 7, -1, 10, -7, 1};

        rst_n = 1'b1; enc_a = 1'b0; enc_b = 1'b0; err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        chk("reset_enc", enc0, 0);
        chk("reset_vv", vv0, 0);
        chk("reset_dir", dir0, 0);
        chk("reset_err", err0, 0);
        tick(3);
        rst_n = 1'b1;

        // table-driven windows on the 100-cycle instance
        wait_vv(0, 2 * W0);
        foreach (vt[k]) begin
            for (int s = 0; s < vt[k].nsteps; s++) mv(vt[k].dirn, vt[k].gap);
            wait_vv(0, 2 * W0);
            chk($sformatf("vec%0d_enc", k), enc0, vt[k].exp_enc);
            chk($sformatf("vec%0d_dir", k), dir0, vt[k].exp_dir);
        end

        // saturation on the 1000-cycle instance
        wait_vv(1, 2 * W1);
        for (int s = 0; s < 150; s++) mv(1, 5);
        wait_vv(1, 2 * W1);
        chk("sat_pos", enc1, 127);
        for (int s = 0; s < 150; s++) mv(-1, 5);
        wait_vv(1, 2 * W1);
        chk("sat_neg", enc1, -128);

        // glitch and illegal transition inside one clean window
        while (pos_tb != 0) mv(1, 5);
        wait_vv(0, 2 * W0);
        enc_a = 1'b1;
        tick(2);
        enc_a = 1'b0;
        tick(6);
        {enc_a, enc_b} = 2'b11;
        pos_tb = 2;
        tick(7);
        chk("illegal_err", err0, 1);
        chk("illegal_err_w1000", err1, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", err0, 0);
        wait_vv(0, 2 * W0);
        chk("glitch_illegal_enc", enc0, 0);

        // step accepted exactly on the window-end cycle
        e2 = cyc + W0;
        while (cyc < e2 - 5) tick(1);
        mv(1, 1);
        wait_vv(0, W0 + 10);
        chk("boundary_cycle", cyc, e2);
        chk("boundary_enc", enc0, 1);
        wait_vv(0, 2 * W0);
        chk("boundary_next_enc", enc0, 0);

        // reset mid-window with 7 steps accumulated
        for (int s = 0; s < 5; s++) mv(1, 5);
        while ((pos_tb + 7) % 4 != 0) mv(1, 5);
        wait_vv(0, 2 * W0);
        chk("pre_reset_enc_nonzero", (enc0 >= 5) ? 1 : 0, 1);
        for (int s = 0; s < 7; s++) mv(1, 4);
        while (cyc % W0 != 50) tick(1);
        rst_n = 1'b0;
        #1;
        chk("midreset_enc", enc0, 0);
        chk("midreset_vv", vv0, 0);
        chk("midreset_dir", dir0, 0);
        chk("midreset_err", err0, 0);
        tick(3);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) mv(1, 5);
        wait_vv(0, 2 * W0);
        chk("post_reset_window_len", cyc, W0);
        chk("post_reset_enc", enc0, 3);

        // randomized traffic, checked continuously against the model
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                pos_tb = (pos_tb + 2) % 4;
                {enc_a, enc_b} = ab_of(pos_tb);
                tick(int'($urandom_range(1, 8)));
            end else if (r < 3) begin
                err_clr = 1'b1;
                mv(($urandom_range(0, 1) == 0) ? 1 : -1, 1);
                err_clr = 1'b0;
            end else begin
                mv(($urandom_range(0, 1) == 0) ? 1 : -1, int'($urandom_range(1, 8)));
            end
        end
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
